// File: rtl/cg_sched_ctrl_if.sv
// Handshake bundle between CNN datapath requesters and the clock-gating scheduler.
// The master drives requests and activity; the slave returns gating enables and readiness.
interface cg_sched_ctrl_if #(
  parameter int NUM_DOM = 4
);
  logic               force_on;
  logic [NUM_DOM-1:0] req;
  logic [NUM_DOM-1:0] busy;
  logic [NUM_DOM-1:0] cg_en;
  logic [NUM_DOM-1:0] rdy;
  logic               waking;

  modport master (
    output force_on, req, busy,
    input  cg_en, rdy, waking
  );

  modport slave (
    input  force_on, req, busy,
    output cg_en, rdy, waking
  );
endinterface

// File: rtl/cg_sched_ctrl.sv
// Per-domain clock-gating scheduler: OFF/WAKE/ON/IDLE FSM per domain with a single-wake round-robin arbiter.
// Outputs are registered from next state, so cg_en rises on the edge after the grant cycle.
module cg_sched_ctrl #(
  parameter int NUM_DOM  = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  cg_sched_ctrl_if.slave     bus
);

  localparam int PTR_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  typedef enum logic [1:0] {S_OFF, S_WAKE, S_ON, S_IDLE} state_e;

  state_e             state_q [NUM_DOM];
  state_e             state_d [NUM_DOM];
  logic [CNT_W-1:0]   cnt_q   [NUM_DOM];
  logic [CNT_W-1:0]   cnt_d   [NUM_DOM];
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_DOM-1:0] cg_en_q, cg_en_d;
  logic [NUM_DOM-1:0] rdy_q, rdy_d;
  logic               waking_q, waking_d;

  logic [NUM_DOM-1:0] wreq, gnt, quiet;
  logic               wake_hold, found;
  int                 idx;

  assign quiet = ~bus.req & ~bus.busy & {NUM_DOM{~bus.force_on}};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DOM; i++) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
      end
      ptr_q    <= '0;
      cg_en_q  <= '0;
      rdy_q    <= '0;
      waking_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DOM; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ptr_q    <= ptr_d;
      cg_en_q  <= cg_en_d;
      rdy_q    <= rdy_d;
      waking_q <= waking_d;
    end
  end

  // Next state: a WAKE in its final cycle does not block the next grant, so wakes chain back to back.
  always_comb begin
    wake_hold = 1'b0;
    wreq      = '0;
    gnt       = '0;
    found     = 1'b0;
    idx       = 0;
    ptr_d     = ptr_q;
    for (int i = 0; i < NUM_DOM; i++) begin
      if (state_q[i] == S_WAKE && cnt_q[i] != CNT_W'(WAKE_CYC - 1)) wake_hold = 1'b1;
      wreq[i] = (state_q[i] == S_OFF) && (bus.req[i] || bus.force_on);
    end
    if (!wake_hold) begin
      for (int k = 0; k < NUM_DOM; k++) begin
        idx = (int'(ptr_q) + k) % NUM_DOM;
        if (!found && wreq[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          ptr_d    = PTR_W'((idx + 1) % NUM_DOM);
        end
      end
    end
    for (int i = 0; i < NUM_DOM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_OFF: begin
          if (gnt[i]) begin
            state_d[i] = S_WAKE;
            cnt_d[i]   = '0;
          end
        end
        S_WAKE: begin
          if (cnt_q[i] == CNT_W'(WAKE_CYC - 1)) begin
            state_d[i] = S_ON;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] != '1) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        S_ON: begin
          if (quiet[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end
        end
        S_IDLE: begin
          if (!quiet[i]) begin
            state_d[i] = S_ON;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_W'(IDLE_CYC - 1)) begin
            state_d[i] = S_OFF;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] != '1) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = S_OFF;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output decode of the next state
  always_comb begin
    cg_en_d  = '0;
    rdy_d    = '0;
    waking_d = 1'b0;
    for (int i = 0; i < NUM_DOM; i++) begin
      cg_en_d[i] = (state_d[i] != S_OFF);
      rdy_d[i]   = (state_d[i] == S_ON) || (state_d[i] == S_IDLE);
      if (state_d[i] == S_WAKE) waking_d = 1'b1;
    end
  end

  assign bus.cg_en  = cg_en_q;
  assign bus.rdy    = rdy_q;
  assign bus.waking = waking_q;

endmodule

// File: tb/tb_cg_sched_ctrl.sv
// Directed bench for cg_sched_ctrl: vector table for wake/round-robin timing plus hand sequences
// for idle hysteresis, force_on, mid-operation reset and req drop during WAKE.
module tb_cg_sched_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cg_sched_ctrl_if #(.NUM_DOM(4)) bus ();

  cg_sched_ctrl #(
    .NUM_DOM (4),
    .WAKE_CYC(2),
    .IDLE_CYC(16),
    .CNT_W   (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic       force_on;
    logic [3:0] req;
    logic [3:0] busy;
    logic [3:0] exp_cg;
    logic [3:0] exp_rdy;
    logic       exp_wk;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [3:0] cg, input logic [3:0] rd, input logic wk);
    chk({nm, "_cg"},  32'(bus.cg_en),  32'(cg));
    chk({nm, "_rdy"}, 32'(bus.rdy),    32'(rd));
    chk({nm, "_wk"},  32'(bus.waking), 32'(wk));
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.force_on = 1'b0;
    bus.req      = '0;
    bus.busy     = '0;
    tick(2);
    chk_all("reset", 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.force_on = 1'b0;
    bus.req      = '0;
    bus.busy     = '0;

    //            force req      busy     cg       rdy      wk
    tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1};
    tbl[2]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1};
    tbl[3]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0};
    tbl[4]  = '{1'b0, 4'b1111, 4'b0000, 4'b0011, 4'b0001, 1'b1};
    tbl[5]  = '{1'b0, 4'b1111, 4'b0000, 4'b0011, 4'b0001, 1'b1};
    tbl[6]  = '{1'b0, 4'b1111, 4'b0000, 4'b0111, 4'b0011, 1'b1};
    tbl[7]  = '{1'b0, 4'b1111, 4'b0000, 4'b0111, 4'b0011, 1'b1};
    tbl[8]  = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0111, 1'b1};
    tbl[9]  = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0111, 1'b1};
    tbl[10] = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1'b0};
    tbl[11] = '{1'b0, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 1'b0};
    tbl[12] = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1'b0};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      bus.force_on = tbl[i].force_on;
      bus.req      = tbl[i].req;
      bus.busy     = tbl[i].busy;
      tick(1);
      chk_all($sformatf("vec%0d", i), tbl[i].exp_cg, tbl[i].exp_rdy, tbl[i].exp_wk);
    end

    // Idle gate-off of domain 0 while the others stay requested
    bus.req = 4'b1110;
    tick(16);
    chk("idle_still_on", 32'(bus.cg_en[0]), 32'd1);
    tick(1);
    chk("idle_off_cg",  32'(bus.cg_en[0]), 32'd0);
    chk("idle_off_rdy", 32'(bus.rdy[0]),   32'd0);

    // busy pulse in IDLE restarts the hysteresis
    bus.req = 4'b1111;
    tick(3);
    chk("rewake_rdy", 32'(bus.rdy), 32'hf);
    bus.req = 4'b1110;
    tick(10);
    bus.busy = 4'b0001;
    tick(1);
    bus.busy = 4'b0000;
    tick(16);
    chk("busy_restart_on", 32'(bus.cg_en[0]), 32'd1);
    tick(1);
    chk("busy_restart_off", 32'(bus.cg_en[0]), 32'd0);

    // req rising on the terminal IDLE cycle keeps the domain on
    bus.req = 4'b1111;
    tick(3);
    chk("rewake2_rdy", 32'(bus.rdy), 32'hf);
    bus.req = 4'b1110;
    tick(16);
    bus.req = 4'b1111;
    tick(1);
    chk("req_wins_cg",  32'(bus.cg_en[0]), 32'd1);
    chk("req_wins_rdy", 32'(bus.rdy[0]),   32'd1);
    tick(1);
    chk("req_wins_hold", 32'(bus.cg_en[0]), 32'd1);

    // Round-robin serialisation from all-OFF
    do_reset();
    bus.req = 4'b1111;
    for (int k = 1; k <= 9; k++) begin
      logic [3:0] ecg, erd;
      ecg = '0;
      erd = '0;
      for (int d = 0; d < 4; d++) begin
        if (k >= 1 + 2 * d) ecg[d] = 1'b1;
        if (k >= 3 + 2 * d) erd[d] = 1'b1;
      end
      tick(1);
      chk_all($sformatf("rr_k%0d", k), ecg, erd, (k <= 8));
      chk($sformatf("rr_onewake_k%0d", k), 32'($countones(bus.cg_en & ~bus.rdy) <= 1), 32'd1);
    end
    // Pointer wrapped to 0: domain 1 beats domain 2
    bus.req = 4'b0000;
    tick(17);
    chk("rr_all_off", 32'(bus.cg_en), 32'h0);
    bus.req = 4'b0110;
    tick(1);
    chk("rr_ptr_wrap", 32'(bus.cg_en), 32'h2);

    // Mid-operation reset with domain 1 in WAKE and domain 0 ON
    do_reset();
    bus.req = 4'b0001;
    tick(3);
    chk("mid_d0_on", 32'(bus.rdy), 32'h1);
    bus.req = 4'b0011;
    tick(1);
    chk("mid_d1_wake", 32'(bus.waking), 32'd1);
    rst_n = 1'b0;
    tick(1);
    chk_all("mid_rst", 4'b0000, 4'b0000, 1'b0);
    rst_n   = 1'b1;
    bus.req = 4'b0110;
    tick(1);
    chk("mid_ptr_reset", 32'(bus.cg_en), 32'h2);

    // force_on wakes everything one at a time and holds it on
    do_reset();
    bus.force_on = 1'b1;
    tick(8);
    chk_all("force_t8", 4'b1111, 4'b0111, 1'b1);
    tick(1);
    chk_all("force_t9", 4'b1111, 4'b1111, 1'b0);
    tick(20);
    chk("force_hold", 32'(bus.rdy), 32'hf);
    bus.force_on = 1'b0;
    tick(16);
    chk("force_fall_on", 32'(bus.cg_en), 32'hf);
    tick(1);
    chk_all("force_fall_off", 4'b0000, 4'b0000, 1'b0);

    // req pulse: WAKE still completes, then idles off
    do_reset();
    bus.req = 4'b1000;
    tick(1);
    bus.req = 4'b0000;
    chk_all("drop_wake", 4'b1000, 4'b0000, 1'b1);
    tick(2);
    chk("drop_on", 32'(bus.rdy), 32'h8);
    tick(16);
    chk("drop_idle", 32'(bus.cg_en), 32'h8);
    tick(1);
    chk("drop_off", 32'(bus.cg_en), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
